// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO.
// Supports optional first-word-fall-through, programmable almost-full and
// almost-empty thresholds, an occupancy count, and sticky overflow and
// underflow flags. Requests that cannot be accepted are dropped in hardware.
module sfifo_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned CNT_BITS  = 5,
  parameter int unsigned FWFT      = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                write_n,
  input  logic                read_n,
  input  logic [CNT_BITS-1:0] af_thresh,
  input  logic [CNT_BITS-1:0] ae_thresh,
  input  logic                clear_err,
  output logic [WIDTH-1:0]    data_out,
  output logic                data_valid,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                half,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [CNT_BITS-1:0]  DEPTH_CNT = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0]  HALF_CNT  = CNT_BITS'((DEPTH + 1) / 2);
  localparam logic [ADDR_BITS-1:0] LAST_PTR  = ADDR_BITS'(DEPTH - 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [CNT_BITS-1:0]  count_q;
  logic                 overflow_q;
  logic                 underflow_q;
  logic                 rd_acc;
  logic                 wr_acc;

  // A read needs data; a write into a full FIFO needs a concurrent accepted read.
  assign rd_acc = ~read_n & (count_q != '0);
  assign wr_acc = ~write_n & ((count_q < DEPTH_CNT) | rd_acc);

  // Pointers wrap at DEPTH-1 (DEPTH need not be a power of two); count tracks occupancy.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ADDR_BITS'(1);
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ADDR_BITS'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array: not reset, and never written during a reset cycle.
  always_ff @(posedge clock) begin
    if (reset_n && wr_acc) mem[wr_ptr] <= data_in;
  end

  // Sticky error flags; a new drop event takes priority over clear_err.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (~write_n & ~wr_acc) overflow_q <= 1'b1;
      else if (clear_err)     overflow_q <= 1'b0;
      if (~read_n & ~rd_acc)  underflow_q <= 1'b1;
      else if (clear_err)     underflow_q <= 1'b0;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // Registered read port: data lands one cycle after the accepted read.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
  end else begin : g_fwft
    // Head word is always presented; read_n acknowledges it.
    assign data_out   = mem[rd_ptr];
    assign data_valid = (count_q != '0);
  end

  // Status decodes of the registered occupancy.
  assign count        = count_q;
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign half         = (count_q >= HALF_CNT);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
